// File: rtl/tick_sched_pkg.sv
// Shared types and default sizing for the tick scheduler.
// Pure declarations, no latency; no flow control involved.
// Config slot fields are sized for the largest legal N_CH/PW and narrowed at use.
package tick_sched_pkg;

    localparam int DEF_PRESCALE = 10000;
    localparam int DEF_N_CH     = 4;
    localparam int DEF_PW       = 16;
    localparam int CH_W_MAX     = 4;
    localparam int PW_MAX       = 32;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    typedef struct packed {
        logic [CH_W_MAX-1:0] ch;
        logic [PW_MAX-1:0]   period;
        logic                en;
    } cfg_t;

endpackage

// File: rtl/tick_scheduler_if.sv
// Config port of the tick scheduler: one channel write per valid/ready transfer.
// No storage, no latency; cfg_ready is driven by the scheduler.
// A transfer happens on a clk edge where cfg_valid && cfg_ready.
interface tick_scheduler_if #(
    parameter int N_CH = 4,
    parameter int PW   = 16
);
    logic                    cfg_valid;
    logic                    cfg_ready;
    logic [$clog2(N_CH)-1:0] cfg_ch;
    logic [PW-1:0]           cfg_period;
    logic                    cfg_en;

    modport master (output cfg_valid, cfg_ch, cfg_period, cfg_en, input cfg_ready);
    modport slave  (input cfg_valid, cfg_ch, cfg_period, cfg_en, output cfg_ready);
endinterface

// File: rtl/tick_channel.sv
// One programmable tick channel: divides base ticks by period, emits tick strobe and sq level.
// tick rises one clk after the base_tick that expires the count; sq toggles with it.
// No backpressure: apply/reload are single-cycle commands from the scheduler.
module tick_channel
    import tick_sched_pkg::*;
#(
    parameter int PW = DEF_PW
) (
    input  logic clk,
    input  logic rst,
    input  logic base_tick,
    input  logic apply,
    input  logic reload,
    input  cfg_t cfg,
    output logic tick,
    output logic sq
);
    logic [PW-1:0] period;
    logic [PW-1:0] cnt;
    logic          en;
    logic [PW-1:0] new_period;
    logic          active;
    logic          new_active;
    logic          unused_cfg;

    assign new_period = cfg.period[PW-1:0];
    assign active     = en && (period != '0);
    assign new_active = cfg.en && (new_period != '0);
    assign unused_cfg = ^{cfg.ch, cfg.period};

    // apply outranks expiry in the same base tick, so a retune never emits a stray strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period <= '0;
            en     <= 1'b0;
            cnt    <= '0;
            tick   <= 1'b0;
            sq     <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (apply) begin
                period <= new_period;
                en     <= cfg.en;
                if (new_active) begin
                    cnt <= new_period - PW'(1);
                    if (reload) sq <= 1'b0;
                end else begin
                    cnt <= '0;
                    sq  <= 1'b0;
                end
            end else if (reload && active) begin
                cnt <= period - PW'(1);
                sq  <= 1'b0;
            end else if (base_tick && active) begin
                if (cnt == '0) begin
                    tick <= 1'b1;
                    sq   <= ~sq;
                    cnt  <= period - PW'(1);
                end else begin
                    cnt <= cnt - PW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/tick_scheduler.sv
// Shared prescaler plus N_CH tick channels, retuned through a config port (phase align: TICK_SCHED_PHASE_ALIGN_EN).
// base_tick every PRESCALE clk; channel ticks lag base_tick by 1; config accept-to-ready up to PRESCALE+1 clk.
// cfg_ready stays low while a write waits for the next base tick; one write in flight.
module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter int PRESCALE = DEF_PRESCALE,
    parameter int N_CH     = DEF_N_CH,
    parameter int PW       = DEF_PW
) (
    input  logic                clk,
    input  logic                rst,
    tick_scheduler_if.slave     cfg,
    output logic                base_tick,
    output logic [N_CH-1:0]     tick,
    output logic [N_CH-1:0]     sq
);
    localparam int PCW = $clog2(PRESCALE);

    logic [PCW-1:0] pre_cnt;
    logic           pre_last;
    state_t         state;
    state_t         state_nxt;
    cfg_t           pend;
    logic           accept;
    logic           apply_all;
    logic           reload;

    assign pre_last = (pre_cnt == PCW'(PRESCALE - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt   <= '0;
            base_tick <= 1'b0;
        end else begin
            pre_cnt   <= pre_last ? '0 : pre_cnt + PCW'(1);
            base_tick <= pre_last;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            pend  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                pend <= {CH_W_MAX'(cfg.cfg_ch), PW_MAX'(cfg.cfg_period), cfg.cfg_en};
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        cfg.cfg_ready = 1'b0;
        accept        = 1'b0;
        apply_all     = 1'b0;
        case (state)
            IDLE: begin
                cfg.cfg_ready = 1'b1;
                if (cfg.cfg_valid) begin
                    accept    = 1'b1;
                    state_nxt = PENDING;
                end
            end
            PENDING: begin
                if (base_tick) begin
                    apply_all = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef TICK_SCHED_PHASE_ALIGN_EN
    assign reload = apply_all;
`else
    assign reload = 1'b0;
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        tick_channel #(.PW(PW)) u_ch (
            .clk       (clk),
            .rst       (rst),
            .base_tick (base_tick),
            .apply     (apply_all && (pend.ch == CH_W_MAX'(i))),
            .reload    (reload),
            .cfg       (pend),
            .tick      (tick[i]),
            .sq        (sq[i])
        );
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler at PRESCALE=4, N_CH=4: every cycle is checked against hand-derived strobe tables.
module tb_tick_scheduler;
    localparam int PRESCALE = 4;
    localparam int N_CH     = 4;
    localparam int PW       = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            base_tick;
    logic [N_CH-1:0] tick;
    logic [N_CH-1:0] sq;

    tick_scheduler_if #(.N_CH(N_CH), .PW(PW)) cif ();

    tick_scheduler #(.PRESCALE(PRESCALE), .N_CH(N_CH), .PW(PW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg       (cif),
        .base_tick (base_tick),
        .tick      (tick),
        .sq        (sq)
    );

    always #5 clk = ~clk;

    int        n_cmp = 0;
    int        n_err = 0;
    int        cyc   = 0;
    logic [3:0] esq;
    logic [3:0] etick;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input int ch, input int p, input logic en);
        cif.cfg_valid  = v;
        cif.cfg_ch     = 2'(ch);
        cif.cfg_period = 16'(p);
        cif.cfg_en     = en;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    // Writes: ch0 p3 @13->apply 17; ch1 p1 @18->21; ch2 p2 @31->33; ch3 p4 @34->37;
    // ch0 off @55->57; ch1 p2 @59->61 (suppresses its tick at 61).
    function automatic logic [3:0] exp_tick(input int c);
        logic [3:0] e;
        e[0] = (c == 29) || (c == 41) || (c == 53);
        e[1] = (c >= 25 && c <= 57 && ((c - 25) % 4) == 0) || (c == 69);
        e[2] = (c >= 41 && ((c - 41) % 8) == 0);
        e[3] = (c == 53) || (c == 69);
        return e;
    endfunction

    function automatic logic exp_rdy(input int c);
        return !((c >= 13 && c <= 16) || (c >= 18 && c <= 20) || (c >= 31 && c <= 32) ||
                 (c >= 34 && c <= 36) || (c >= 55 && c <= 56) || (c >= 59 && c <= 60) ||
                 (c == 73));
    endfunction

    initial begin
        drive(1'b0, 0, 0, 1'b0);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("reset_outputs", 32'({base_tick, tick, sq, cif.cfg_ready}), 32'h001);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        esq = '0;

        for (int c = 1; c <= 73; c++) begin
            step();
            etick = exp_tick(cyc);
            esq   = esq ^ etick;
            if (cyc == 57) esq[0] = 1'b0;
            chk("base_tick", 32'(base_tick), 32'(cyc % PRESCALE == 0));
            chk("cfg_ready", 32'(cif.cfg_ready), 32'(exp_rdy(cyc)));
            chk("tick", 32'(tick), 32'(etick));
            chk("sq", 32'(sq), 32'(esq));
            case (cyc)
                12: drive(1'b1, 0, 3, 1'b1);
                13: drive(1'b0, 0, 0, 1'b0);
                17: drive(1'b1, 1, 1, 1'b1);
                18: drive(1'b0, 0, 0, 1'b0);
                30: drive(1'b1, 2, 2, 1'b1);
                31: drive(1'b1, 3, 4, 1'b1);
                34: drive(1'b0, 0, 0, 1'b0);
                54: drive(1'b1, 0, 3, 1'b0);
                55: drive(1'b0, 0, 0, 1'b0);
                58: drive(1'b1, 1, 2, 1'b1);
                59: drive(1'b0, 0, 0, 1'b0);
                72: drive(1'b1, 2, 1, 1'b1);
                default: ;
            endcase
        end

        // cycle 73: ch2 strobe is high and a ch2 write is pending
        drive(1'b0, 0, 0, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrun_reset", 32'({base_tick, tick, sq, cif.cfg_ready}), 32'h001);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        for (int c = 1; c <= 40; c++) begin
            step();
            chk("post_rst_base", 32'(base_tick), 32'(cyc % PRESCALE == 0));
            chk("post_rst_ready", 32'(cif.cfg_ready), 32'h1);
            chk("post_rst_tick", 32'(tick), 32'h0);
            chk("post_rst_sq", 32'(sq), 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tick_scheduler.md
Name: tick_scheduler

Overview:
- One shared prescaler drives N_CH programmable tick channels.
- Each channel emits one-cycle enable strobes and a square-wave level at a runtime-set period, counted in base ticks.
- Replaces per-consumer derived clocks (display scan, debounce, game timers); every consumer stays on clk and uses the strobes as enables.
- Channels are reprogrammed through a valid/ready config port; updates take effect only on a base-tick boundary, so retunes are glitch-free.

Parameters:
- PRESCALE, 10000, clk cycles per base tick; 100 MHz clk gives a 10 kHz base; minimum 2.
- N_CH, 4, number of tick channels; must be a power of two, 2..16.
- PW, 16, period register width in base ticks.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- cfg_valid  in  1  config request
- cfg_ready  out  1  config port can accept
- cfg_ch  in  $clog2(N_CH)  target channel
- cfg_period  in  PW  period in base ticks; 0 forces the channel off
- cfg_en  in  1  channel enable
- base_tick  out  1  one-cycle strobe every PRESCALE clk cycles
- tick  out  N_CH  per-channel one-cycle strobes
- sq  out  N_CH  per-channel square waves (toggle on each tick)

Behaviour:
Reset:
- Reset is asynchronous. Outputs: base_tick=0, tick=0, sq=0, cfg_ready=1.
- Prescaler count=0; all channels en=0, period=0, cnt=0; FSM=IDLE.

Prescaler:
- pre_cnt runs 0..PRESCALE-1 and wraps.
- base_tick is registered: high for exactly one cycle after each clk edge at which pre_cnt==PRESCALE-1.
- The first base_tick pulse follows the PRESCALE-th edge after reset release; the period is exactly PRESCALE cycles.

Config FSM, states IDLE and PENDING:
- IDLE: cfg_ready=1. On cfg_valid, latch (ch, period, en) into a pending slot and go to PENDING. cfg_ready drops on the next cycle.
- PENDING: cfg_ready=0. On the cycle base_tick=1, apply the pending slot to the channel and return to IDLE; cfg_ready=1 on the following cycle.
- Worst-case accept-to-ready latency is PRESCALE+1 cycles.

Apply:
- Set channel period and en. Active means en=1 and period!=0.
- If active: cnt<=period-1, sq unchanged, no tick this base tick.
- If inactive: tick=0, sq<=0.

Channel, on each base_tick while active:
- cnt==0: tick[i] is high for the next cycle only, sq[i] toggles, cnt<=period-1.
- Otherwise: cnt<=cnt-1.
- Result: tick period = period*PRESCALE clk; sq period = 2*period*PRESCALE.
- Period 1 gives a tick on every base tick.
- Inactive channels hold tick=0 and sq=0.

Boundary cases:
- Apply and expiry in the same base tick: apply wins; the expiring tick is suppressed.
- cfg_valid held high through PENDING: not accepted again until IDLE. The next transfer requires cfg_valid&&cfg_ready.
- Reset mid-PENDING: the pending write is discarded and all channels are off.
- tick and base_tick are never high in the same cycle (tick lags base_tick by exactly one cycle).

Optional Feature:
- Macro TICK_SCHED_PHASE_ALIGN_EN.
- Defined: every apply also reloads cnt<=period-1 on all active channels and clears sq on all of them, in the same cycle. This phase-aligns every channel to the write.
- Undefined: only the written channel is reloaded; other channels run undisturbed.

Decomposition:
- Package tick_sched_pkg:
  - FSM state enum {IDLE, PENDING}.
  - Struct cfg_t {ch, period, en}.
  - Default PRESCALE/N_CH/PW constants.
- Sub-module tick_channel: holds the per-channel cnt/period/en/sq/tick.
  - Inputs: base_tick, apply, reload, cfg.
  - Instantiated N_CH times by generate.
- Top holds the prescaler and the FSM.

Test Plan:
1. PRESCALE=4, N_CH=4. Release rst, then sample base_tick → high on cycles 4, 8, 12, …; tick=0 and sq=0 throughout; cfg_ready=1.
2. Write ch0 period=3 en=1 → cfg_ready low until the apply base tick. Then tick[0] pulses every 12 cycles, the first one 13 cycles after apply (12 after the apply base tick plus the 1-cycle lag); sq[0] period is 24.
3. Write ch1 period=1 → tick[1] every 4 cycles, each pulse one cycle after base_tick; sq[1] toggles every 4 cycles.
4. Hold cfg_valid for two back-to-back writes → the second is accepted only after cfg_ready returns. Its apply lands on the next base tick, 4 cycles after the first apply.
5. Write ch0 period=0, or en=0, mid-run → at apply, tick[0] stops and sq[0]=0; ch1 continues unchanged (macro undefined) or is realigned with sq[1]=0 (macro defined).
6. Assert rst during PENDING and mid-pulse → all outputs 0 immediately and cfg_ready=1; after release no channel ticks until reprogrammed.
